demux_stream: RTL and testbench
===============================

Name: demux_stream

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each accepted input word goes to the output channel given by its select. Each channel holds one word in its own buffer, so a stalled channel blocks only writes aimed at it.
- Successor to the combinational demux family. Used as the fan-out stage ahead of per-channel consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- N_OUT, 8, number of output channels (>=2; need not be a power of two)
- SEL_W, $clog2(N_OUT), select width (derived; do not override)
- ZERO_IDLE, 1, 1 = out_data slice of a channel reads all-zero while that channel's out_valid=0; 0 = slice holds the last word

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  input word
- in_sel  in  SEL_W  destination channel for in_data
- in_valid  in  1  input word present
- in_ready  out  1  block can accept the input word this cycle
- out_data  out  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  out  N_OUT  channel k buffer holds a word
- out_ready  in  N_OUT  consumer of channel k takes the word this cycle
- drop_count  out  8  saturating count of words dropped for an out-of-range select

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0 for all channels.
  - All channel data registers=0, so out_data=0.
  - drop_count=0.
- Channel k is full when out_valid[k]=1. Pop of channel k happens when out_valid[k] && out_ready[k].
- Range check: in_sel is in range when in_sel < N_OUT.
- in_ready is combinational:
  - in range: in_ready = !out_valid[in_sel] || out_ready[in_sel]. Same-cycle pop frees the slot, giving full throughput per channel.
  - out of range: in_ready = 1.
  - Path out_ready -> in_ready is permitted and documented.
- Accept = in_valid && in_ready. On an accept with an in-range select, at the next rising edge:
  - channel in_sel data register <= in_data
  - out_valid[in_sel] <= 1
- Latency: 1 cycle from accept to out_valid.
- Pop without a new write: out_valid[k] <= 0 at the edge. The data register holds its value, and is masked by ZERO_IDLE.
- Simultaneous pop and write on the same channel: the new word is loaded and out_valid stays 1. No bubble, no loss.
- Writes to channel j and pops on other channels are independent in the same cycle.
- Out-of-range accept (possible only when N_OUT is not a power of two):
  - word discarded, no channel touched
  - drop_count increments, saturating at 255
- Data stability: out_data slice k and out_valid[k] must not change while out_valid[k]=1 && out_ready[k]=0.
- in_valid=0: no state change except pops. in_sel and in_data are don't-care.
- Reset mid-operation: all buffered words are lost. Outputs return to reset values immediately on rst assertion, without waiting for clk.
- No combinational path from in_data or in_sel to out_data or out_valid (all outputs registered, except in_ready).

Test Plan:
- Reset/idle (N_OUT=8, WIDTH=8), rst=1 mid-stream with 3 channels full:
  - out_valid=8'h00, out_data=0, drop_count=0 before the next clk edge
  - in_ready=1 for any in_sel
- Basic routing, all out_ready=1, send in_sel=0..7 with in_data=8'hA0+sel on consecutive cycles:
  - each out_valid[k] pulses one cycle, one cycle after its accept, with slice k=8'hA0+k
  - every other slice reads 0 (ZERO_IDLE=1)
- Backpressure, out_ready[3]=0:
  - send 8'h11 to ch3: accepted, out_valid[3]=1
  - send 8'h22 to ch3: in_ready=0, stalls
  - 8'h33 to ch5 in between: accepted
  - raise out_ready[3] for one cycle: 8'h11 popped and 8'h22 loaded in the same edge
- Streaming, ch2 with out_ready[2]=1: four back-to-back words 1,2,3,4 give in_ready held 1 and out_valid[2] high for 4 consecutive cycles, with data 1,2,3,4.
- Drop path (N_OUT=5):
  - in_sel=6, in_valid=1 for 300 cycles: in_ready=1, no out_valid rises, drop_count saturates at 255
  - then in_sel=1 with 8'h5A: delivered normally
- ZERO_IDLE=0: after ch1 pops 8'hC3, slice 1 still reads 8'hC3 with out_valid[1]=0.

Source files
------------

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N valid/ready demultiplexer with a one-word buffer per channel
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT),
  parameter bit ZERO_IDLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [7:0]               drop_count
);
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] wr;
  logic [N_OUT*WIDTH-1:0] data_q;
  logic drop;
  // hit is all-zero for an out-of-range select, which makes such words always acceptable
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) hit[k] = in_sel == SEL_W'(k);
  end
  assign in_ready = ~|hit | |(hit & (~out_valid | out_ready));
  assign wr = hit & {N_OUT{in_valid & in_ready}};
  assign drop = in_valid & ~|hit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      data_q <= '0;
      drop_count <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (wr[k]) begin
          data_q[k*WIDTH +: WIDTH] <= in_data;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
  always_comb begin
    out_data = data_q;
    for (int k = 0; k < N_OUT; k++)
      out_data[k*WIDTH +: WIDTH] = (ZERO_IDLE && !out_valid[k]) ? '0 : data_q[k*WIDTH +: WIDTH];
  end
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed checks of routing, backpressure, streaming, drop path and idle masking
module tb_demux_stream;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic [7:0] d8, s8_dummy;
  logic [2:0] s8;
  logic v8, rdy8;
  logic [63:0] od8;
  logic [7:0] ov8, r8, dc8;

  logic [7:0] d5;
  logic [2:0] s5;
  logic v5, rdy5;
  logic [39:0] od5;
  logic [4:0] ov5, r5;
  logic [7:0] dc5;

  logic [7:0] dz;
  logic [2:0] sz;
  logic vz, rdyz;
  logic [63:0] odz;
  logic [7:0] ovz, rz, dcz;

  int n_tests = 0, n_fail = 0;

  demux_stream #(.WIDTH(8), .N_OUT(8), .ZERO_IDLE(1)) u8 (
    .clk(clk), .rst(rst), .in_data(d8), .in_sel(s8), .in_valid(v8), .in_ready(rdy8),
    .out_data(od8), .out_valid(ov8), .out_ready(r8), .drop_count(dc8));
  demux_stream #(.WIDTH(8), .N_OUT(5), .ZERO_IDLE(1)) u5 (
    .clk(clk), .rst(rst), .in_data(d5), .in_sel(s5), .in_valid(v5), .in_ready(rdy5),
    .out_data(od5), .out_valid(ov5), .out_ready(r5), .drop_count(dc5));
  demux_stream #(.WIDTH(8), .N_OUT(8), .ZERO_IDLE(0)) uz (
    .clk(clk), .rst(rst), .in_data(dz), .in_sel(sz), .in_valid(vz), .in_ready(rdyz),
    .out_data(odz), .out_valid(ovz), .out_ready(rz), .drop_count(dcz));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    r8 = 8'h00; v8 = 1;
    for (int k = 0; k < 3; k++) begin
      s8 = 3'(k); d8 = 8'h70 + 8'(k);
      step();
    end
    v8 = 0;
    chk("prefill_valid", 64'(ov8), 64'h07);
    #2 rst = 1;
    #1;
    chk("rst_out_valid", 64'(ov8), 64'h00);
    chk("rst_out_data", od8, 64'h0);
    chk("rst_drop_count", 64'(dc8), 64'h0);
    for (int k = 0; k < 8; k++) begin
      s8 = 3'(k);
      #1;
      chk("rst_in_ready", 64'(rdy8), 64'h1);
    end
    step();
    rst = 0;
  endtask

  task automatic test_routing();
    logic [63:0] exp;
    r8 = 8'hFF; v8 = 1;
    for (int k = 0; k < 8; k++) begin
      s8 = 3'(k); d8 = 8'hA0 + 8'(k);
      #1;
      chk("route_in_ready", 64'(rdy8), 64'h1);
      step();
      exp = '0;
      exp[k*8 +: 8] = 8'hA0 + 8'(k);
      chk("route_valid", 64'(ov8), 64'(8'h01 << k));
      chk("route_data", od8, exp);
    end
    v8 = 0;
    step();
    chk("route_idle_valid", 64'(ov8), 64'h0);
    chk("route_idle_data", od8, 64'h0);
  endtask

  task automatic test_backpressure();
    r8 = 8'hF7; v8 = 1; s8 = 3; d8 = 8'h11;
    #1;
    chk("bp_first_ready", 64'(rdy8), 64'h1);
    step();
    chk("bp_first_valid", 64'(ov8), 64'h08);
    chk("bp_first_data", 64'(od8[31:24]), 64'h11);
    d8 = 8'h22;
    #1;
    chk("bp_stall_ready", 64'(rdy8), 64'h0);
    step();
    chk("bp_stall_valid", 64'(ov8), 64'h08);
    chk("bp_stall_hold", 64'(od8[31:24]), 64'h11);
    s8 = 5; d8 = 8'h33;
    #1;
    chk("bp_other_ready", 64'(rdy8), 64'h1);
    step();
    chk("bp_other_valid", 64'(ov8), 64'h28);
    chk("bp_other_data", 64'(od8[47:40]), 64'h33);
    chk("bp_ch3_hold", 64'(od8[31:24]), 64'h11);
    s8 = 3; d8 = 8'h22;
    #1;
    chk("bp_still_stalled", 64'(rdy8), 64'h0);
    step();
    chk("bp_ch5_popped", 64'(ov8), 64'h08);
    r8 = 8'hFF;
    #1;
    chk("bp_release_ready", 64'(rdy8), 64'h1);
    step();
    chk("bp_swap_valid", 64'(ov8), 64'h08);
    chk("bp_swap_data", 64'(od8[31:24]), 64'h22);
    v8 = 0;
    step();
    chk("bp_drain", 64'(ov8), 64'h0);
  endtask

  task automatic test_back_to_back();
    r8 = 8'hFF; v8 = 1; s8 = 2;
    for (int i = 1; i <= 4; i++) begin
      d8 = 8'(i);
      #1;
      chk("stream_ready", 64'(rdy8), 64'h1);
      step();
      chk("stream_valid", 64'(ov8), 64'h04);
      chk("stream_data", 64'(od8[23:16]), 64'(i));
    end
    v8 = 0;
    step();
    chk("stream_end", 64'(ov8), 64'h0);
  endtask

  task automatic test_drop();
    int bad_ready = 0, bad_valid = 0;
    r5 = 5'h1F; v5 = 1; s5 = 6; d5 = 8'hEE;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (rdy5 !== 1'b1) bad_ready++;
      step();
      if (ov5 !== 5'h0) bad_valid++;
      if (i == 9) chk("drop_count_10", 64'(dc5), 64'd10);
    end
    chk("drop_ready_errs", 64'(bad_ready), 64'd0);
    chk("drop_valid_errs", 64'(bad_valid), 64'd0);
    chk("drop_saturate", 64'(dc5), 64'd255);
    s5 = 1; d5 = 8'h5A;
    step();
    v5 = 0;
    chk("drop_after_valid", 64'(ov5), 64'h02);
    chk("drop_after_data", 64'(od5), 64'h5A00);
    chk("drop_after_count", 64'(dc5), 64'd255);
  endtask

  task automatic test_zero_idle_off();
    rz = 8'h00; vz = 1; sz = 1; dz = 8'hC3;
    step();
    vz = 0;
    chk("zi0_valid", 64'(ovz), 64'h02);
    rz = 8'h02;
    step();
    chk("zi0_popped", 64'(ovz), 64'h0);
    chk("zi0_hold_data", 64'(odz[15:8]), 64'hC3);
  endtask

  initial begin
    s8_dummy = 0;
    d8 = 0; s8 = 0; v8 = 0; r8 = 0;
    d5 = 0; s5 = 0; v5 = 0; r5 = 0;
    dz = 0; sz = 0; vz = 0; rz = 0;
    step();
    step();
    rst = 0;
    test_reset();
    test_routing();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_zero_idle_off();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
